// File: rtl/periph_bus_pkg.sv
// periph_bus_pkg: shared definitions for the peripheral bus sequencer.
//   - region codes decoded from addr[15:12]
//   - sequencer state encoding (exposed on dbg_state)
//   - counter widths and small decode helpers
package periph_bus_pkg;

  localparam logic [3:0] REG_RAM   = 4'h8;
  localparam logic [3:0] REG_GFX   = 4'h9;
  localparam logic [3:0] REG_AUDIO = 4'hA;
  localparam logic [3:0] REG_SPART = 4'hB;
  localparam logic [3:0] REG_PS2   = 4'hC;

  // Wait-state values are 4 bits; the shared timer is 8 bits so it can
  // also hold the ack timeout.
  localparam int WS_W  = 4;
  localparam int TMR_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_ACKWAIT = 3'd3,
    ST_DONE    = 3'd4
  } bus_state_e;

  function automatic logic region_mapped(input logic [3:0] code);
    return (code >= REG_RAM) && (code <= REG_PS2);
  endfunction

  function automatic logic region_is_ack(input logic [3:0] code);
    return (code == REG_SPART) || (code == REG_PS2);
  endfunction

  // Bit order: {ps2, spart, audio, graphics, ram}
  function automatic logic [4:0] region_onehot(input logic [3:0] code);
    logic [4:0] oh;
    oh = 5'b0;
    case (code)
      REG_RAM:   oh = 5'b00001;
      REG_GFX:   oh = 5'b00010;
      REG_AUDIO: oh = 5'b00100;
      REG_SPART: oh = 5'b01000;
      REG_PS2:   oh = 5'b10000;
      default:   oh = 5'b00000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/periph_bus_ctrl_bus_wait_timer.sv
// bus_wait_timer: loadable down-counter shared by wait-state counting and
// the ack timeout.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : load load_val (takes priority over dec)
//   load_val  : value to load
//   dec       : decrement by one, saturating at zero
//   done      : count currently equals 1, i.e. this is the last counted cycle
module bus_wait_timer
  import periph_bus_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == W'(1));

endmodule

// File: rtl/periph_bus_ctrl.sv
// periph_bus_ctrl: sequencer between the CPU memory port and the shared
// 16-bit peripheral DataBus.
//
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   req_read, req_write      : CPU request levels, sampled only in IDLE
//   addr, wdata              : CPU address / write data
//   rdata, ready, bus_err    : response; ready is a one-cycle pulse
//   bus_addr, bus_wdata      : registered address nibble / write data
//   bus_rd, bus_wr           : registered strobes
//   bus_rdata, periph_ack    : peripheral read data / ack (SPART, PS2)
//   cs_*                     : registered one-hot chip selects
//   dbg_state                : current sequencer state (bus_state_e)
//
// Optional feature: define BUS_TIMEOUT_EN to abort an ACKWAIT that sees no
// ack within TIMEOUT_CYC cycles (bus_err=1, rdata=0).
//
// Handshake: a request is taken when exactly one of req_read/req_write is
// high in IDLE; completion is the single cycle in which ready=1, with rdata
// and bus_err valid only in that cycle. No backpressure exists on ready.
module periph_bus_ctrl
  import periph_bus_pkg::*;
#(
  parameter int WS_RAM      = 0,
  parameter int WS_GFX      = 1,
  parameter int WS_AUDIO    = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ready,
  output logic        bus_err,
  output logic [3:0]  bus_addr,
  output logic [15:0] bus_wdata,
  output logic        bus_rd,
  output logic        bus_wr,
  input  logic [15:0] bus_rdata,
  input  logic        periph_ack,
  output logic        cs_ram,
  output logic        cs_graphics,
  output logic        cs_audio,
  output logic        cs_spart,
  output logic        cs_ps2,
  output logic [2:0]  dbg_state
);

  bus_state_e  state_q, state_d;
  logic [3:0]  region_q, region_d;
  logic        rd_q, rd_d;
  logic [3:0]  bus_addr_q, bus_addr_d;
  logic [15:0] bus_wdata_q, bus_wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic [4:0]  cs_q, cs_d;
  logic        bus_rd_q, bus_rd_d;
  logic        bus_wr_q, bus_wr_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;

  logic              tmr_load;
  logic              tmr_dec;
  logic              tmr_done;
  logic [TMR_W-1:0]  tmr_val;
  logic              active_d;

  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[11:4];

  // Value loaded in SETUP: wait states for counted regions, the timeout
  // budget for ack regions.
  always_comb begin
    tmr_val = '0;
    case (region_q)
      REG_RAM:   tmr_val = TMR_W'(WS_RAM);
      REG_GFX:   tmr_val = TMR_W'(WS_GFX);
      REG_AUDIO: tmr_val = TMR_W'(WS_AUDIO);
      REG_SPART: tmr_val = TMR_W'(TIMEOUT_CYC);
      REG_PS2:   tmr_val = TMR_W'(TIMEOUT_CYC);
      default:   tmr_val = '0;
    endcase
  end

  bus_wait_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .done     (tmr_done)
  );

  always_comb begin
    state_d     = state_q;
    region_d    = region_q;
    rd_d        = rd_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    err_d       = 1'b0;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_read || req_write) begin
          if ((req_read && req_write) || !region_mapped(addr[15:12])) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d     = ST_SETUP;
            region_d    = addr[15:12];
            rd_d        = req_read;
            bus_addr_d  = addr[3:0];
            bus_wdata_d = wdata;
          end
        end
      end
      ST_SETUP: begin
        // periph_ack is deliberately not looked at here.
        tmr_load = 1'b1;
        if (region_is_ack(region_q)) begin
          state_d = ST_ACKWAIT;
        end else if (tmr_val == '0) begin
          state_d = ST_DONE;
          if (rd_q) rdata_d = bus_rdata;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        tmr_dec = 1'b1;
        if (tmr_done) begin
          state_d = ST_DONE;
          if (rd_q) rdata_d = bus_rdata;
        end
      end
      ST_ACKWAIT: begin
        tmr_dec = 1'b1;
        if (periph_ack) begin
          state_d = ST_DONE;
          if (rd_q) rdata_d = bus_rdata;
        end
`ifdef BUS_TIMEOUT_EN
        else if (tmr_done) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they change only on
    // the clock edge and line up with the state they belong to.
    active_d = (state_d == ST_SETUP) || (state_d == ST_WAIT) ||
               (state_d == ST_ACKWAIT);
    cs_d     = active_d ? region_onehot(region_d) : 5'b0;
    bus_rd_d = active_d && rd_d;
    bus_wr_d = active_d && !rd_d;
    ready_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      region_q    <= '0;
      rd_q        <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
      cs_q        <= '0;
      bus_rd_q    <= 1'b0;
      bus_wr_q    <= 1'b0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      region_q    <= region_d;
      rd_q        <= rd_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
      cs_q        <= cs_d;
      bus_rd_q    <= bus_rd_d;
      bus_wr_q    <= bus_wr_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
    end
  end

  assign rdata       = rdata_q;
  assign ready       = ready_q;
  assign bus_err     = err_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wdata   = bus_wdata_q;
  assign bus_rd      = bus_rd_q;
  assign bus_wr      = bus_wr_q;
  assign cs_ram      = cs_q[0];
  assign cs_graphics = cs_q[1];
  assign cs_audio    = cs_q[2];
  assign cs_spart    = cs_q[3];
  assign cs_ps2      = cs_q[4];
  assign dbg_state   = state_q;

endmodule

// File: doc/periph_bus_ctrl.md
Name: periph_bus_ctrl

Overview:
- Sequencer between the CPU's external memory port and the shared 16-bit peripheral DataBus.
- Decodes address regions into one-hot chip selects and holds address, data and strobes stable for the whole access.
- Inserts per-region wait states (RAM, graphics, audio) or runs an ack handshake (SPART, PS2).
- Returns a one-cycle `ready` pulse with captured read data; unmapped accesses are flagged with `bus_err`.

Parameters:
- WS_RAM, 0, wait cycles added for RAM region (0..15)
- WS_GFX, 1, wait cycles added for graphics region (0..15)
- WS_AUDIO, 2, wait cycles added for audio region (0..15)
- TIMEOUT_CYC, 64, max cycles waiting for `periph_ack` (used only with BUS_TIMEOUT_EN; 2..255)

Ports:
- clk  in  1  system clock (cpuclk domain)
- rst  in  1  asynchronous reset, active-high
- req_read  in  1  CPU read request, level, sampled only in IDLE
- req_write  in  1  CPU write request, level, sampled only in IDLE
- addr  in  16  CPU address
- wdata  in  16  CPU write data
- rdata  out  16  read data to CPU, valid while `ready`=1
- ready  out  1  one-cycle transaction-complete pulse
- bus_err  out  1  error flag, valid with `ready`
- bus_addr  out  4  low address nibble to peripherals (registered)
- bus_wdata  out  16  write data to peripherals (registered)
- bus_rd  out  1  read strobe to peripherals
- bus_wr  out  1  write strobe to peripherals
- bus_rdata  in  16  peripheral read data
- periph_ack  in  1  completion from SPART/PS2
- cs_ram, cs_graphics, cs_audio, cs_spart, cs_ps2  out  1 each  one-hot chip selects

Behaviour:
- Reset (async, immediate): all cs_*=0, bus_rd=0, bus_wr=0, ready=0, bus_err=0, rdata=0, bus_addr=0, bus_wdata=0, state=IDLE. Reset mid-transaction aborts it with no `ready` pulse.
- Region decode on addr[15:12]:
  - 0x8 RAM
  - 0x9 graphics
  - 0xA audio
  - 0xB SPART (ack)
  - 0xC PS2 (ack)
  - all other values unmapped
- States: IDLE, SETUP, WAIT, ACKWAIT, DONE.
- IDLE:
  - Exactly one of req_read/req_write=1 and region mapped -> latch addr[3:0], wdata and direction; go to SETUP.
  - Unmapped region, or both requests=1 -> DONE with err=1, no cs or strobe asserted, rdata=0.
  - Neither request -> stay in IDLE.
- SETUP (1 cycle): selected cs_* and bus_rd/bus_wr=1. Counter loads the region's WS value.
  - Ack region -> ACKWAIT.
  - WS=0 -> DONE.
  - Otherwise -> WAIT.
- WAIT: decrement counter each cycle; leave for DONE in the cycle counter==1. cs and strobe stay asserted.
- ACKWAIT: cs and strobe stay asserted until periph_ack=1 is sampled, then -> DONE. An ack present in the SETUP cycle is ignored.
- Capture: on the edge leaving SETUP/WAIT/ACKWAIT toward DONE, rdata<=bus_rdata for reads; rdata is left unchanged for writes.
- DONE (1 cycle): ready=1, bus_err as determined, all cs and strobes=0 -> IDLE.
- Latency from the request-sampling edge to ready=1: 2+WS cycles for counted regions, 3 for an immediate ack, 1 for errors.
- Requests held high after ready start a new transaction from IDLE, giving back-to-back accesses with one idle cycle.
- Invariants:
  - At most one cs_* high at any time.
  - bus_rd and bus_wr are never high together.
  - Outputs are registered and glitch-free.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined: an 8-bit timer counts ACKWAIT cycles. On reaching TIMEOUT_CYC without ack -> DONE with bus_err=1, rdata=0.
- Undefined: ACKWAIT waits indefinitely; bus_err is set only for unmapped or conflicting requests.

Decomposition:
- Package periph_bus_pkg holds:
  - region codes (REG_RAM=4'h8 ... REG_PS2=4'hC)
  - state encoding
  - counter widths
- One sub-module, bus_wait_timer: loadable down-counter with `done` flag, reused for the wait-state count and the timeout count.

Test Plan:
- WS_RAM=0, read 0x8012 with bus_rdata=0xBEEF -> cs_ram high 1 cycle, bus_addr=0x2, ready 2 cycles after request, rdata=0xBEEF, bus_err=0.
- Write 0xA005 with data 0x1234, WS_AUDIO=2 -> cs_audio+bus_wr high 3 cycles, bus_wdata=0x1234, ready at cycle 4.
- Read 0xB001, periph_ack asserted 5 cycles after cs_spart -> cs held until ack, rdata captured, one ready pulse.
- Read 0x3000 -> no cs or strobe, ready next cycle with bus_err=1, rdata=0. Same response for req_read=req_write=1 on 0x8000.
- BUS_TIMEOUT_EN, TIMEOUT_CYC=64, PS2 read with no ack -> bus_err=1 after 64 ACKWAIT cycles. Without the macro, still waiting at 1000 cycles.
- Assert rst during a graphics WAIT -> all cs and strobes drop within the same cycle, no ready pulse. A request after reset completes normally.
